// File: rtl/result_stream_sink_if.sv
// result_stream_sink_if: ap_fifo write side plus valid/ready drain side of the result sink.
interface result_stream_sink_if;
  logic        result_stream_full_n;
  logic [96:0] result_stream_wr_data;
  logic        result_stream_wr_en;
  logic        out_valid;
  logic [96:0] out_data;
  logic        out_ready;
  modport master (
    input  result_stream_full_n, out_valid, out_data,
    output result_stream_wr_data, result_stream_wr_en, out_ready
  );
  modport slave (
    input  result_stream_wr_data, result_stream_wr_en, out_ready,
    output result_stream_full_n, out_valid, out_data
  );
endinterface

// File: rtl/result_stream_sink.sv
// result_stream_sink: ap_fifo result responder buffering into a FIFO drained by valid/ready.
// Optional hit/miss counters when RESULT_SINK_STATS_EN is defined.
module result_stream_sink #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic aclk,
  input  logic aresetn,
  result_stream_sink_if.slave s,
  output logic overflow_err
`ifdef RESULT_SINK_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam logic [ADDR_W:0] P_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] P_DEPTH = (ADDR_W+1)'(DEPTH);
  logic [96:0]     r_mem [DEPTH];
  logic [ADDR_W:0] r_wptr, r_rptr, r_count;
  logic            r_full_n, r_valid, r_ovf;
  logic [96:0]     r_head;
  logic            w_wr, w_rd;
  logic [ADDR_W:0] w_count_next, w_rptr_next, w_wptr_next;
  logic [96:0]     w_head_next;
  assign w_wr = s.result_stream_wr_en && r_full_n;
  assign w_rd = r_valid && s.out_ready;
  always_comb begin
    w_count_next = (w_wr && !w_rd) ? r_count + P_ONE :
                   (w_rd && !w_wr) ? r_count - P_ONE : r_count;
    w_rptr_next  = w_rd ? r_rptr + P_ONE : r_rptr;
    w_wptr_next  = w_wr ? r_wptr + P_ONE : r_wptr;
    // the word being written this cycle becomes head when the FIFO would otherwise be empty
    w_head_next  = (w_wr && r_wptr == w_rptr_next) ? s.result_stream_wr_data
                                                    : r_mem[w_rptr_next[ADDR_W-1:0]];
  end
  always_ff @(posedge aclk)
    if (w_wr) r_mem[r_wptr[ADDR_W-1:0]] <= s.result_stream_wr_data;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full_n <= 1'b1;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wptr   <= w_wptr_next;
      r_rptr   <= w_rptr_next;
      r_count  <= w_count_next;
      r_full_n <= w_count_next != P_DEPTH;
      r_valid  <= w_count_next != '0;
      r_ovf    <= r_ovf || (s.result_stream_wr_en && !r_full_n);
      // hold the head while empty so uninitialised storage never reaches out_data
      if (w_count_next != '0) r_head <= w_head_next;
    end
  assign s.result_stream_full_n = r_full_n;
  assign s.out_valid            = r_valid;
  assign s.out_data             = r_head;
  assign overflow_err           = r_ovf;
`ifdef RESULT_SINK_STATS_EN
  logic [31:0] r_hit, r_miss;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_hit  <= '0;
      r_miss <= '0;
    end else if (w_wr) begin
      if (s.result_stream_wr_data[0]) r_hit <= r_hit + 32'd1;
      else r_miss <= r_miss + 32'd1;
    end
  assign hit_count  = r_hit;
  assign miss_count = r_miss;
`endif
endmodule

// File: tb/tb_result_stream_sink.sv
// tb_result_stream_sink: scoreboard bench for result_stream_sink (RESULT_SINK_STATS_EN optional).
module tb_result_stream_sink;
  localparam int DEPTH = 16;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic overflow_err;
`ifdef RESULT_SINK_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  result_stream_sink_if bus();
  result_stream_sink #(.DEPTH(DEPTH)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s(bus),
    .overflow_err(overflow_err)
`ifdef RESULT_SINK_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  always #5 aclk = ~aclk;
  int          n_chk = 0;
  int          n_err = 0;
  logic [96:0] q[$];
  logic        exp_ovf;
  logic [31:0] exp_hit, exp_miss;
  int          k, cyc;
  logic        w;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [96:0] mk(input logic i, input logic [31:0] t, u, v);
    return {v, u, t, i};
  endfunction
  task automatic check_outputs();
    check("out_valid", bus.out_valid, q.size() != 0);
    check("full_n", bus.result_stream_full_n, q.size() != DEPTH);
    if (q.size() != 0) check("out_data", bus.out_data, q[0]);
    check("overflow_err", overflow_err, exp_ovf);
`ifdef RESULT_SINK_STATS_EN
    check("hit_count", hit_count, exp_hit);
    check("miss_count", miss_count, exp_miss);
`endif
  endtask
  task automatic cycle(input logic wr, input logic [96:0] d, input logic rdy);
    logic rd, wa;
    check_outputs();
    bus.result_stream_wr_en   = wr;
    bus.result_stream_wr_data = d;
    bus.out_ready             = rdy;
    rd = rdy && q.size() != 0;
    wa = wr && q.size() != DEPTH;
    if (wr && !wa) exp_ovf = 1'b1;
    if (rd) void'(q.pop_front());
    if (wa) begin
      q.push_back(d);
      if (d[0]) exp_hit++;
      else exp_miss++;
    end
    @(negedge aclk);
  endtask
  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_full_n", bus.result_stream_full_n, 1'b1);
    check("rst_overflow", overflow_err, 1'b0);
`ifdef RESULT_SINK_STATS_EN
    check("rst_hit", hit_count, 32'd0);
    check("rst_miss", miss_count, 32'd0);
`endif
    q.delete();
    exp_ovf = 1'b0; exp_hit = '0; exp_miss = '0;
    bus.result_stream_wr_en = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask
  initial begin
    bus.result_stream_wr_en = 1'b0; bus.result_stream_wr_data = '0; bus.out_ready = 1'b0;
    exp_ovf = 1'b0; exp_hit = '0; exp_miss = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    check("rst_out_data", bus.out_data, 97'd0);
    // single hit result straight through
    cycle(1'b1, mk(1'b1, 32'h40A00000, 32'h3E800000, 32'h3F800000), 1'b1);
    check("t1_data", bus.out_data, {32'h3F800000, 32'h3E800000, 32'h40A00000, 1'b1});
    repeat (3) cycle(1'b0, '0, 1'b1);
    // fill to DEPTH, then one more write that must be dropped
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, mk(i[0], i, ~i, 32'hA000 + i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("t2_ovf", overflow_err, 1'b1);
    repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1);
    // full, then a read while a write stays pending across the pointer wrap
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk(i[0], 32'hB000 + i, i, i), 1'b0);
    cycle(1'b1, mk(1'b1, 32'hCAFE, 32'h1, 32'h2), 1'b1);
    cycle(1'b1, mk(1'b1, 32'hCAFE, 32'h1, 32'h2), 1'b0);
    cycle(1'b0, '0, 1'b0);
    repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1);
    // random traffic, 1000 alternating hit/miss results
    do_reset();
    k = 0; cyc = 0;
    while (k < 1000 && cyc < 20000) begin
      w = $urandom_range(0, 1) == 1 && q.size() < DEPTH;
      cycle(w, mk(~k[0], $urandom, $urandom, $urandom), $urandom_range(0, 1) == 1);
      if (w) k++;
      cyc++;
    end
    repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1);
    check("rand_count", k, 1000);
    check("rand_ovf", overflow_err, 1'b0);
`ifdef RESULT_SINK_STATS_EN
    check("rand_hit", hit_count, 32'd500);
    check("rand_miss", miss_count, 32'd500);
`endif
    // reset with 5 entries buffered, then a fresh write must come out first
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(1'b0, 32'hD000 + i, 0, 0), 1'b0);
    do_reset();
    cycle(1'b1, mk(1'b1, 32'hE1E1, 32'hE2E2, 32'hE3E3), 1'b0);
    check("post_rst_data", bus.out_data, mk(1'b1, 32'hE1E1, 32'hE2E2, 32'hE3E3));
    repeat (3) cycle(1'b0, '0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
